// File: rtl/um_ingress_pkt_buf.sv
// Store-and-forward ingress buffer in front of um pktin_*.
// Only complete, committed packets are released; bad packets are dropped whole.
module um_ingress_pkt_buf #(
    parameter int ADDR_W        = 8,
    parameter int PKT_ADDR_W    = 4,
    parameter int MAX_PKT_WORDS = 96
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_data_wr,
    input  logic [133:0] in_data,
    input  logic         in_data_valid_wr,
    input  logic         in_data_valid,
    output logic         in_ready,
    output logic         out_data_wr,
    output logic [133:0] out_data,
    output logic         out_data_valid_wr,
    output logic         out_data_valid,
    input  logic         out_ready,
    output logic [31:0]  drop_cnt,
    output logic [15:0]  frame_err_cnt
);
    localparam int PW = ADDR_W + 1;
    localparam int DW = PKT_ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH  = PW'(1 << ADDR_W);
    localparam logic [PW-1:0] MAX_W  = PW'(MAX_PKT_WORDS);
    localparam logic [PW-1:0] ONE    = PW'(1);
    localparam logic [DW-1:0] DDEPTH = DW'(1 << PKT_ADDR_W);

    typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} r_state_t;

    logic [133:0]      mem [1 << ADDR_W];
    logic [133:0]      ram_q;
    logic [PW-1:0]     desc_start [1 << PKT_ADDR_W];
    logic [PW-1:0]     desc_len   [1 << PKT_ADDR_W];

    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;
    logic [PW-1:0]     wr_ptr, wr_ptr_nxt, pkt_start, pkt_start_nxt;
    logic [PW-1:0]     rd_ptr, used, free;
    logic              ram_full;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr, ram_raddr;
    logic              push, pop, drop_inc, ferr_inc;
    logic [DW-1:0]     dw_ptr, dr_ptr;
    logic              desc_empty, desc_full;
    logic [PW-1:0]     head_start, head_len;
    logic [PW-1:0]     cur_start, cur_len, sent;
    logic [ADDR_W-1:0] cur_addr;
    logic              load, last;
    logic [1:0]        w_type;
    logic              is_head, is_tail, commit_ok;

    assign w_type     = in_data[133:132];
    assign is_head    = in_data_wr && (w_type == 2'b01);
    assign is_tail    = in_data_wr && (w_type == 2'b10);
    assign commit_ok  = in_data_valid_wr && in_data_valid;
    // used includes the packet still being written, so it is never readable
    assign used       = wr_ptr - rd_ptr;
    assign ram_full   = (used == DEPTH);
    assign free       = DEPTH - used;
    assign desc_empty = (dw_ptr == dr_ptr);
    assign desc_full  = ((dw_ptr - dr_ptr) == DDEPTH);
    assign head_start = desc_start[dr_ptr[PKT_ADDR_W-1:0]];
    assign head_len   = desc_len[dr_ptr[PKT_ADDR_W-1:0]];

    always_comb begin
        w_next        = w_state;
        wr_ptr_nxt    = wr_ptr;
        pkt_start_nxt = pkt_start;
        mem_we        = 1'b0;
        mem_waddr     = wr_ptr[ADDR_W-1:0];
        push          = 1'b0;
        drop_inc      = 1'b0;
        ferr_inc      = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (is_head) begin
                    pkt_start_nxt = wr_ptr;
                    if (ram_full || desc_full) begin
                        w_next = W_DROP;
                    end else begin
                        mem_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + ONE;
                        w_next     = W_PKT;
                    end
                end else if (in_data_wr) begin
                    ferr_inc = 1'b1;
                end
            end
            W_PKT: begin
                if (is_head) begin
                    // restart in place: the new head overwrites the partial packet
                    ferr_inc  = 1'b1;
                    drop_inc  = 1'b1;
                    mem_waddr = pkt_start[ADDR_W-1:0];
                    if (desc_full) begin
                        wr_ptr_nxt = pkt_start;
                        w_next     = W_DROP;
                    end else begin
                        mem_we     = 1'b1;
                        wr_ptr_nxt = pkt_start + ONE;
                    end
                end else if (is_tail) begin
                    w_next = W_IDLE;
                    if (ram_full || !commit_ok) begin
                        wr_ptr_nxt = pkt_start;
                        drop_inc   = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + ONE;
                        push       = 1'b1;
                    end
                end else if (in_data_wr) begin
                    if (ram_full) begin
                        w_next = W_DROP;
                    end else begin
                        mem_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + ONE;
                    end
                end
            end
            W_DROP: begin
                if (is_tail) begin
                    wr_ptr_nxt = pkt_start;
                    drop_inc   = 1'b1;
                    w_next     = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            wr_ptr        <= '0;
            pkt_start     <= '0;
            dw_ptr        <= '0;
            drop_cnt      <= '0;
            frame_err_cnt <= '0;
        end else begin
            w_state       <= w_next;
            wr_ptr        <= wr_ptr_nxt;
            pkt_start     <= pkt_start_nxt;
            drop_cnt      <= drop_cnt + 32'(drop_inc);
            frame_err_cnt <= frame_err_cnt + 16'(ferr_inc);
            if (push) dw_ptr <= dw_ptr + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= in_data;
        ram_q <= mem[ram_raddr];
        if (push) begin
            desc_start[dw_ptr[PKT_ADDR_W-1:0]] <= pkt_start;
            desc_len[dw_ptr[PKT_ADDR_W-1:0]]   <= wr_ptr + ONE - pkt_start;
        end
    end

    always_comb begin
        r_next    = r_state;
        pop       = 1'b0;
        load      = 1'b0;
        last      = 1'b0;
        ram_raddr = cur_addr;
        unique case (r_state)
            R_IDLE: begin
                if (!desc_empty && out_ready) begin
                    pop       = 1'b1;
                    ram_raddr = head_start[ADDR_W-1:0];
                    r_next    = R_FETCH;
                end
            end
            R_FETCH: begin
                load   = 1'b1;
                r_next = R_SEND;
            end
            R_SEND: begin
                load = 1'b1;
                if (sent + ONE == cur_len) begin
                    last   = 1'b1;
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= R_IDLE;
            dr_ptr            <= '0;
            rd_ptr            <= '0;
            cur_start         <= '0;
            cur_len           <= '0;
            sent              <= '0;
            cur_addr          <= '0;
            out_data_wr       <= 1'b0;
            out_data          <= '0;
            out_data_valid_wr <= 1'b0;
            out_data_valid    <= 1'b0;
        end else begin
            r_state <= r_next;
            if (pop) begin
                dr_ptr    <= dr_ptr + DW'(1);
                cur_start <= head_start;
                cur_len   <= head_len;
                cur_addr  <= head_start[ADDR_W-1:0] + ADDR_W'(1);
                sent      <= '0;
            end
            if (load) begin
                cur_addr          <= cur_addr + ADDR_W'(1);
                sent              <= sent + ONE;
                out_data_wr       <= 1'b1;
                out_data          <= ram_q;
                out_data_valid_wr <= last;
                out_data_valid    <= last;
            end else begin
                out_data_wr       <= 1'b0;
                out_data          <= '0;
                out_data_valid_wr <= 1'b0;
                out_data_valid    <= 1'b0;
            end
            if (last) rd_ptr <= cur_start + cur_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready <= 1'b1;
        else     in_ready <= (free >= MAX_W) && !desc_full;
    end
endmodule

// File: tb/tb_um_ingress_pkt_buf.sv
// Bench for um_ingress_pkt_buf: directed cases plus random packets
// checked against a packet-level queue model.
module tb_um_ingress_pkt_buf;
    localparam int ADDR_W = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_data_wr;
    logic [133:0] in_data;
    logic         in_data_valid_wr;
    logic         in_data_valid;
    logic         in_ready;
    logic         out_data_wr;
    logic [133:0] out_data;
    logic         out_data_valid_wr;
    logic         out_data_valid;
    logic         out_ready;
    logic [31:0]  drop_cnt;
    logic [15:0]  frame_err_cnt;

    int checks = 0;
    int errors = 0;
    int m_drop = 0;
    int m_ferr = 0;
    logic [133:0] exp_q[$];
    bit           exp_last[$];
    int           gap_q[$];
    int cyc = 0, last_cyc = 0, widx = 0, total_out = 0;
    bit in_pkt = 0, seen_any = 0;

    um_ingress_pkt_buf #(
        .ADDR_W(ADDR_W), .PKT_ADDR_W(4), .MAX_PKT_WORDS(96)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data_wr(in_data_wr), .in_data(in_data),
        .in_data_valid_wr(in_data_valid_wr), .in_data_valid(in_data_valid),
        .in_ready(in_ready),
        .out_data_wr(out_data_wr), .out_data(out_data),
        .out_data_valid_wr(out_data_valid_wr), .out_data_valid(out_data_valid),
        .out_ready(out_ready),
        .drop_cnt(drop_cnt), .frame_err_cnt(frame_err_cnt)
    );

    always #5 clk = ~clk;

    // output monitor: every emitted word must be the next committed word
    always @(negedge clk) begin
        logic [133:0] w;
        bit           l;
        int           g;
        cyc++;
        if (rst) begin
            exp_q.delete();
            exp_last.delete();
            in_pkt = 0;
            seen_any = 0;
            widx = 0;
        end else if (out_data_wr) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_word got=%h want=none", out_data);
            end
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                l = exp_last.pop_front();
                checks++;
                assert (out_data === w) else begin
                    errors++;
                    $error("FAIL out_data got=%h want=%h", out_data, w);
                end
                checks++;
                assert (out_data_valid_wr === l) else begin
                    errors++;
                    $error("FAIL valid_wr got=%b want=%b", out_data_valid_wr, l);
                end
                checks++;
                assert (out_data_valid === l) else begin
                    errors++;
                    $error("FAIL valid got=%b want=%b", out_data_valid, l);
                end
            end
            if (!in_pkt) begin
                if (seen_any) begin
                    g = cyc - last_cyc - 1;
                    gap_q.push_back(g);
                    checks++;
                    assert (g >= 1) else begin
                        errors++;
                        $error("FAIL pkt_gap got=%0d want>=1", g);
                    end
                end
                in_pkt = 1;
            end
            widx++;
            total_out++;
            last_cyc = cyc;
            if (out_data_valid_wr) begin
                in_pkt = 0;
                widx = 0;
                seen_any = 1;
            end
        end else begin
            checks++;
            assert (!in_pkt) else begin
                errors++;
                $error("FAIL mid_pkt_gap got=0 want=1");
            end
            checks++;
            assert (out_data_valid_wr === 1'b0) else begin
                errors++;
                $error("FAIL stray_valid_wr got=%b want=0", out_data_valid_wr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic logic [133:0] mk(input logic [1:0] t);
        return {t, 4'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [133:0] w, input logic vwr,
                             input logic v);
        in_data_wr       = 1'b1;
        in_data          = w;
        in_data_valid_wr = vwr;
        in_data_valid    = v;
        @(posedge clk);
        #1;
        in_data_wr       = 1'b0;
        in_data          = '0;
        in_data_valid_wr = 1'b0;
        in_data_valid    = 1'b0;
    endtask

    // model: a packet is forwarded iff its tail commits and it fits
    task automatic send_pkt(input int len, input logic good, input bit fits);
        logic [133:0] pk[$];
        logic [133:0] w;
        for (int i = 0; i < len; i++) begin
            w = mk(i == 0 ? 2'b01 : (i == len - 1 ? 2'b10 : 2'b11));
            pk.push_back(w);
            send_word(w, i == len - 1, good && (i == len - 1));
        end
        if (good && fits) begin
            foreach (pk[i]) begin
                exp_q.push_back(pk[i]);
                exp_last.push_back(i == len - 1);
            end
        end else begin
            m_drop++;
        end
    endtask

    task automatic wait_ready();
        idle(2);
        for (int i = 0; i < 3000 && !in_ready; i++) begin
            out_ready = 1'b1;
            idle(1);
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || in_pkt) && n < budget) begin
            idle(1);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        idle(3);
    endtask

    initial begin
        int t;
        int g1, g2;
        int n;
        rst = 1'b1;
        in_data_wr = 1'b0;
        in_data = '0;
        in_data_valid_wr = 1'b0;
        in_data_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_wr", 32'(out_data_wr), 32'd0);
        chk("rst_out_data", 32'(out_data != '0), 32'd0);
        chk("rst_valid_wr", 32'(out_data_valid_wr), 32'd0);
        chk("rst_valid", 32'(out_data_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_drop", drop_cnt, 32'd0);
        chk("rst_ferr", 32'(frame_err_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single good packet
        out_ready = 1'b1;
        wait_ready();
        send_pkt(6, 1'b1, 1'b1);
        drain(100);
        chk("t1_drop", drop_cnt, 32'(m_drop));

        // discarded packet then a good one
        wait_ready();
        send_pkt(6, 1'b0, 1'b1);
        wait_ready();
        send_pkt(6, 1'b1, 1'b1);
        drain(100);
        chk("t2_drop", drop_cnt, 32'(m_drop));

        // stray body while idle, then head inside a packet
        idle(2);
        send_word(mk(2'b11), 1'b0, 1'b0);
        m_ferr++;
        send_word(mk(2'b01), 1'b0, 1'b0);
        send_word(mk(2'b11), 1'b0, 1'b0);
        send_word(mk(2'b11), 1'b0, 1'b0);
        m_ferr++;
        m_drop++;
        send_pkt(5, 1'b1, 1'b1);
        drain(100);
        chk("t3_ferr", 32'(frame_err_cnt), 32'(m_ferr));
        chk("t3_drop", drop_cnt, 32'(m_drop));

        // held back by out_ready, then back-to-back release
        out_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            wait_ready();
            send_pkt(6, 1'b1, 1'b1);
        end
        t = total_out;
        idle(20);
        chk("t4_held", 32'(total_out - t), 32'd0);
        gap_q.delete();
        out_ready = 1'b1;
        drain(200);
        chk("t4_words", 32'(total_out - t), 32'd18);
        chk("t4_pkts", 32'(gap_q.size()), 32'd3);
        g1 = gap_q.size() > 1 ? gap_q[1] : -1;
        g2 = gap_q.size() > 2 ? gap_q[2] : -1;
        chk("t4_gap1", 32'(g1), 32'd1);
        chk("t4_gap2", 32'(g2), 32'd1);

        // oversized packet overflows the RAM and is dropped
        wait_ready();
        t = total_out;
        for (int i = 0; i < 140; i++) begin
            send_word(mk(i == 0 ? 2'b01 : (i == 139 ? 2'b10 : 2'b11)),
                      i == 139, i == 139);
        end
        m_drop++;
        idle(5);
        chk("t5_none_out", 32'(total_out - t), 32'd0);
        chk("t5_drop", drop_cnt, 32'(m_drop));
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        // a full-depth packet fits only if all space was reclaimed
        send_pkt(1 << ADDR_W, 1'b1, 1'b1);
        drain(600);

        // reset in the middle of sending
        wait_ready();
        send_pkt(6, 1'b1, 1'b1);
        n = 0;
        while (widx != 2 && n < 100) begin
            idle(1);
            n++;
        end
        chk("t6_reach_w3", 32'(widx), 32'd2);
        rst = 1'b1;
        m_drop = 0;
        m_ferr = 0;
        @(negedge clk);
        chk("t6_out_wr", 32'(out_data_wr), 32'd0);
        chk("t6_out_data", 32'(out_data != '0), 32'd0);
        chk("t6_valid_wr", 32'(out_data_valid_wr), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_drop", drop_cnt, 32'd0);
        chk("t6_ferr", 32'(frame_err_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
        chk("t6_no_resume", 32'(in_pkt), 32'd0);
        wait_ready();
        send_pkt(6, 1'b1, 1'b1);
        wait_ready();
        send_pkt(4, 1'b1, 1'b1);
        drain(100);

        // random packets, commits, stray words and backpressure
        for (int p = 0; p < 40; p++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) begin
                idle(1);
                send_word(mk(2'b11), 1'b0, 1'b0);
                m_ferr++;
            end
            wait_ready();
            send_pkt(int'($urandom_range(2, 10)),
                     $urandom_range(0, 3) != 0, 1'b1);
        end
        out_ready = 1'b1;
        drain(3000);
        chk("rand_drop", drop_cnt, 32'(m_drop));
        chk("rand_ferr", 32'(frame_err_cnt), 32'(m_ferr));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
